// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: destination-register scoreboard, RAW stall/bubble control and halt drain/park FSM.
// Optional build macro REGFILE_BYPASS_EN: the WB slot is not checked because the regfile forwards same-cycle writes.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exp_read1,
  input  logic [REG_ADDR_W-1:0] exp_addr1,
  input  logic                  exp_read2,
  input  logic [REG_ADDR_W-1:0] exp_addr2,
  input  logic                  tar_we,
  input  logic [REG_ADDR_W-1:0] tar_addr,
  input  logic                  stop,
  input  logic                  resume,
  output logic                  bbl,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt
);

`ifdef REGFILE_BYPASS_EN
  localparam int LIM = DEPTH - 1;
`else
  localparam int LIM = DEPTH;
`endif
  localparam int DCNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t                r_state, w_state_next;
  logic [DCNT_W-1:0]     r_dcnt, w_dcnt_next;
  logic                  r_valid [DEPTH];
  logic [REG_ADDR_W-1:0] r_addr  [DEPTH];
  logic [CNT_W-1:0]      r_stall_cnt;
  logic                  w_hz;
  logic                  w_run;
  logic                  w_issue;

  assign w_run   = (r_state == ST_RUN);
  assign bbl     = w_hz | ~w_run | stop;
  assign w_issue = w_run & ~bbl;
  assign halted  = (r_state == ST_HALTED);
  assign stall_cnt = r_stall_cnt;

  // Slots only ever hold non-zero addresses, so x0 reads can never match.
  always_comb begin
    w_hz = 1'b0;
    for (int i = 0; i < LIM; i++) begin
      if (r_valid[i] && ((exp_read1 && (exp_addr1 == r_addr[i])) ||
                         (exp_read2 && (exp_addr2 == r_addr[i]))))
        w_hz = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dcnt_next  = r_dcnt;
    case (r_state)
      ST_RUN: begin
        if (stop) begin
          w_state_next = ST_DRAIN;
          w_dcnt_next  = DCNT_W'(DEPTH);
        end
      end
      ST_DRAIN: begin
        w_dcnt_next = r_dcnt - 1'b1;
        if (r_dcnt == DCNT_W'(1))
          w_state_next = ST_HALTED;
      end
      ST_HALTED: begin
        if (resume)
          w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_dcnt  <= w_dcnt_next;
    end
  end

  // Scoreboard shift: slot 0 takes the issuing instruction, the oldest slot falls off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_addr[i]  <= '0;
      end
    end else begin
      r_valid[0] <= tar_we & (tar_addr != '0) & w_issue;
      r_addr[0]  <= tar_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  // Halt request takes priority over counting a coincident hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_run && w_hz && !stop && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule
